// File: rtl/rob_alloc.sv
// ROB slot allocator: tail/head pointers, occupancy count and RUN/FLUSH control.
// Optional statistics outputs are enabled with the ROB_ALLOC_STATS_EN macro.
module rob_alloc #(
  parameter int ROB_SLOTS    = 16,
  parameter int ROB_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    alloc_req_i,
  output logic                    alloc_gnt_o,
  output logic [ROB_IDX_BITS-1:0] alloc_idx_o,
  input  logic                    retire_i,
  input  logic [ROB_IDX_BITS-1:0] retire_idx_i,
  input  logic                    except_i,
  output logic                    stall_o,
  output logic [ROB_IDX_BITS:0]   count_o,
  output logic                    full_o,
  output logic                    empty_o,
`ifdef ROB_ALLOC_STATS_EN
  output logic [ROB_IDX_BITS:0]   hi_water_o,
  output logic [31:0]             full_cycles_o,
`endif
  output logic                    err_order_o
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [ROB_IDX_BITS:0]   CNT_FULL_C = (ROB_IDX_BITS+1)'(ROB_SLOTS);
  localparam logic [ROB_IDX_BITS:0]   CNT_ZERO_C = {(ROB_IDX_BITS+1){1'b0}};
  localparam logic [ROB_IDX_BITS:0]   CNT_ONE_C  = (ROB_IDX_BITS+1)'(1);
  localparam logic [ROB_IDX_BITS-1:0] IDX_ZERO_C = {ROB_IDX_BITS{1'b0}};
  localparam logic [ROB_IDX_BITS-1:0] IDX_ONE_C  = ROB_IDX_BITS'(1);

  state_e                  state_q, state_d;
  logic [ROB_IDX_BITS-1:0] head_q, head_d;
  logic [ROB_IDX_BITS-1:0] tail_q, tail_d;
  logic [ROB_IDX_BITS:0]   count_q, count_d;
  logic                    err_q, err_d;
  logic                    gnt_s, acc_s, flush_s, full_s;

  assign full_s = (count_q == CNT_FULL_C);

  // Next-state for the control FSM, pointers, occupancy and the sticky order error
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    gnt_s   = 1'b0;
    acc_s   = 1'b0;
    flush_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        flush_s = clear_i | (retire_i & except_i);
        // A full ROB never grants, even when a retire frees a slot this cycle.
        gnt_s   = alloc_req_i & ~full_s & ~flush_s;
        acc_s   = retire_i & (count_q != CNT_ZERO_C);
        if (retire_i && ((count_q == CNT_ZERO_C) || (retire_idx_i != head_q))) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (flush_s) begin
          state_d = ST_FLUSH;
          head_d  = IDX_ZERO_C;
          tail_d  = IDX_ZERO_C;
          count_d = CNT_ZERO_C;
        end else begin
          state_d = ST_RUN;
          if (gnt_s) begin
            tail_d = tail_q + IDX_ONE_C;
          end else begin
            tail_d = tail_q;
          end
          if (acc_s) begin
            head_d = head_q + IDX_ONE_C;
          end else begin
            head_d = head_q;
          end
          case ({gnt_s, acc_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
          endcase
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control and pointer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      head_q  <= IDX_ZERO_C;
      tail_q  <= IDX_ZERO_C;
      count_q <= CNT_ZERO_C;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign alloc_gnt_o = gnt_s & ~rst;
  assign alloc_idx_o = tail_q;
  assign stall_o     = alloc_req_i & ~alloc_gnt_o;
  assign count_o     = count_q;
  assign full_o      = full_s;
  assign empty_o     = (count_q == CNT_ZERO_C);
  assign err_order_o = err_q;

`ifdef ROB_ALLOC_STATS_EN
  logic [ROB_IDX_BITS:0] hi_water_q, hi_water_d;
  logic [31:0]           full_cycles_q, full_cycles_d;

  // High-water mark survives flushes; full-cycle counter saturates
  always_comb begin
    hi_water_d    = hi_water_q;
    full_cycles_d = full_cycles_q;
    if (count_d > hi_water_q) begin
      hi_water_d = count_d;
    end else begin
      hi_water_d = hi_water_q;
    end
    if (alloc_req_i && full_s && (full_cycles_q != 32'hFFFF_FFFF)) begin
      full_cycles_d = full_cycles_q + 32'd1;
    end else begin
      full_cycles_d = full_cycles_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_water_q    <= CNT_ZERO_C;
      full_cycles_q <= 32'd0;
    end else begin
      hi_water_q    <= hi_water_d;
      full_cycles_q <= full_cycles_d;
    end
  end

  assign hi_water_o    = hi_water_q;
  assign full_cycles_o = full_cycles_q;
`endif

endmodule
